// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM encoding and legal parameter ranges.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;
    localparam int DIV_MIN    = 1;
    localparam int DIV_MAX    = 16;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_rate_divider.sv
// Bit-period divider: counts DIV clk cycles per serial bit while active.
// Latency: strobe/last decoded directly from div_cnt. No backpressure; clear restarts the period.
module bit_rate_divider
    import serializer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic bit_strobe,
    output logic bit_last
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear || !active) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST_CNT) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign bit_strobe = active && (div_cnt == '0);
    assign bit_last   = active && (div_cnt == LAST_CNT);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter, MSB- or LSB-first, each bit held DIV clk cycles.
// Latency: first bit appears the cycle after accept. Backpressure: din_ready only in idle or last bit cycle.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              msb_first,
    output logic              serial_out,
    output logic              bit_strobe,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_param
        $error("bit_serializer: DATA_W or DIV out of range");
    end

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              order_msb;
    logic              rst_done;
    logic              bit_last;
    logic              word_last;
    logic              accept;
    logic              shifting;

    assign shifting = (state == SHIFT);

    bit_rate_divider #(
        .DIV(DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .active    (shifting),
        .bit_strobe(bit_strobe),
        .bit_last  (bit_last)
    );

    assign word_last = bit_last && (bit_cnt == LAST_BIT);
    // rst_done keeps din_ready low until the first edge after reset release.
    assign din_ready = rst_done && ((state == IDLE) || word_last);
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= next_state;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (word_last && !accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            order_msb <= 1'b0;
        end else if (accept) begin
            shreg     <= din;
            bit_cnt   <= '0;
            order_msb <= msb_first;
        end else if (word_last) begin
            shreg     <= '0;
            bit_cnt   <= '0;
        end else if (bit_last) begin
            shreg     <= order_msb ? (shreg << 1) : (shreg >> 1);
            bit_cnt   <= bit_cnt + BIT_W'(1);
        end
    end

    // Current bit sits at the end of the register the word shifts towards.
    assign serial_out = shifting && (order_msb ? shreg[DATA_W-1] : shreg[0]);
    assign busy       = shifting;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: DIV=1 instance (a) and DIV=4 instance (b).
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic       din_valid_a, din_valid_b;
    logic       msb_a, msb_b;
    logic       ready_a, ready_b;
    logic       so_a, so_b;
    logic       strobe_a, strobe_b;
    logic       busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .DIV(1)) dut_a (
        .clk(clk), .reset(reset), .din(din_a), .din_valid(din_valid_a),
        .din_ready(ready_a), .msb_first(msb_a), .serial_out(so_a),
        .bit_strobe(strobe_a), .busy(busy_a)
    );

    bit_serializer #(.DATA_W(8), .DIV(4)) dut_b (
        .clk(clk), .reset(reset), .din(din_b), .din_valid(din_valid_b),
        .din_ready(ready_b), .msb_first(msb_b), .serial_out(so_b),
        .bit_strobe(strobe_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] stream;
        logic        cap [0:16];
        int          det1, det2, first_det, nstrobe;

        reset = 1'b0;
        din_a = '0; din_valid_a = 1'b0; msb_a = 1'b0;
        din_b = '0; din_valid_b = 1'b0; msb_b = 1'b0;

        // Reset state while reset is held low
        #3;
        chk("rst_ready", ready_a, 0);
        chk("rst_so", so_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_strobe", strobe_a, 0);
        #9 reset = 1'b1;
        step();
        chk("rel_ready", ready_a, 1);

        // Idle for 20 cycles with din_valid low
        for (int c = 0; c < 20; c++) begin
            chk("idle_so", so_a, 0);
            chk("idle_busy", busy_a, 0);
            chk("idle_ready", ready_a, 1);
            step();
        end

        // 8'hE0 MSB first: 1,1,1,0,0,0,0,0; one detection at cycle 3
        w = 8'hE0;
        din_a = w; msb_a = 1'b1; din_valid_a = 1'b1;
        step();
        din_valid_a = 1'b0; din_a = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            chk("e0_so", so_a, w[7-k]);
            chk("e0_busy", busy_a, 1);
            chk("e0_strobe", strobe_a, 1);
            chk("e0_ready", ready_a, (k == 7));
            cap[k] = so_a;
            step();
        end
        cap[8] = so_a;
        chk("e0_end_so", so_a, 0);
        chk("e0_end_busy", busy_a, 0);
        det1 = 0; first_det = -1;
        for (int k = 3; k <= 9; k++) begin
            if (cap[k-3] && cap[k-2] && cap[k-1]) begin
                det1++;
                if (first_det < 0) first_det = k;
            end
        end
        chk("e0_det_count", det1, 1);
        chk("e0_det_cycle", first_det, 3);

        // 8'h01 LSB first; msb_first toggled mid-word must be ignored
        w = 8'h01;
        din_a = w; msb_a = 1'b0; din_valid_a = 1'b1;
        step();
        din_valid_a = 1'b0; msb_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("lsb_so", so_a, (k == 0));
            chk("lsb_busy", busy_a, 1);
            chk("lsb_ready", ready_a, (k == 7));
            step();
        end
        chk("lsb_end_busy", busy_a, 0);
        chk("lsb_end_so", so_a, 0);

        // Back-to-back 8'hFF then 8'h0F with din_valid held high
        stream = 16'hFF0F;
        din_a = 8'hFF; msb_a = 1'b1; din_valid_a = 1'b1;
        step();
        din_a = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) din_valid_a = 1'b0;
            chk("b2b_so", so_a, stream[15-k]);
            chk("b2b_busy", busy_a, 1);
            chk("b2b_ready", ready_a, (k == 7 || k == 15));
            cap[k] = so_a;
            step();
        end
        cap[16] = so_a;
        chk("b2b_end_busy", busy_a, 0);
        det1 = 0; det2 = 0;
        for (int k = 3; k <= 17; k++) begin
            if (cap[k-3] && cap[k-2] && cap[k-1]) begin
                if (k - 1 <= 7) det1++;
                else det2++;
            end
        end
        chk("b2b_det_word1", det1, 6);
        chk("b2b_det_word2", det2, 2);

        // DIV=4, 8'hA5 MSB first: 32 cycles, 8 strobes
        w = 8'hA5;
        din_b = w; msb_b = 1'b1; din_valid_b = 1'b1;
        step();
        din_valid_b = 1'b0;
        nstrobe = 0;
        for (int c = 0; c < 32; c++) begin
            chk("div4_so", so_b, w[7 - c/4]);
            chk("div4_strobe", strobe_b, (c % 4 == 0));
            chk("div4_busy", busy_b, 1);
            chk("div4_ready", ready_b, (c == 31));
            if (strobe_b) nstrobe++;
            step();
        end
        chk("div4_nstrobe", nstrobe, 8);
        chk("div4_end_busy", busy_b, 0);
        chk("div4_end_so", so_b, 0);

        // Reset after bit 3 of 8'hFF discards the rest of the word
        din_a = 8'hFF; msb_a = 1'b1; din_valid_a = 1'b1;
        step();
        din_valid_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rstmid_so", so_a, 1);
            step();
        end
        #2 reset = 1'b0;
        #1;
        chk("rstmid_async_so", so_a, 0);
        chk("rstmid_async_busy", busy_a, 0);
        chk("rstmid_async_ready", ready_a, 0);
        #2 reset = 1'b1;
        step();
        chk("rstmid_rel_ready", ready_a, 1);
        for (int c = 0; c < 10; c++) begin
            chk("rstmid_after_so", so_a, 0);
            chk("rstmid_after_busy", busy_a, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
